// File: rtl/io_hub_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | io_hub_pkg : I/O window addresses, status bit positions, LFSR step      |
// | Revision   : 1.0                                                        |
// +-------------------------------------------------------------------------+
package io_hub_pkg;

  localparam logic [15:0] IO_TIMER  = 16'h00FC;
  localparam logic [15:0] IO_STATUS = 16'h00FD;
  localparam logic [15:0] IO_RANDOM = 16'h00FE;
  localparam logic [15:0] IO_KEY    = 16'h00FF;

  localparam int ST_OVF   = 7;
  localparam int ST_TZERO = 6;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Right-shifting Galois step; a non-zero state never maps to zero.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_hub_key_fifo.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | key_fifo : synchronous FIFO with flush and sticky overflow-on-full flag |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
module key_fifo #(
  parameter  int DEPTH = 8,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic          i_ovf_clr,
  output logic [DW-1:0] o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_overflow
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_do_pop;
  logic w_do_push;
  logic w_drop;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_head     = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

  // A pop in the same cycle frees the slot, so a push to a full FIFO is kept.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign w_drop    = i_push & o_full & ~w_do_pop;

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_hub.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | io_hub   : 6502 I/O window decode, key FIFO, LFSR, 60 Hz-style timer    |
// |            Optional KEY_AUTOREPEAT_EN adds held-key auto-repeat pushes. |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
module io_hub
  import io_hub_pkg::*;
#(
  parameter int         ADDR_W    = 16,
  parameter int         KEY_DEPTH = 8,
  parameter logic [7:0] RAND_SEED = 8'hA5,
  parameter int         TICK_DIV  = 833333
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read_write,
  input  logic [7:0]        cpu_data_write,
  input  logic [7:0]        mem_data,
  input  logic              key_valid,
  input  logic [7:0]        key_code,
  output logic [7:0]        cpu_data_read,
  output logic              key_irq
);

  localparam int CW = $clog2(KEY_DEPTH) + 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic          r_key_prev;
  logic [7:0]    r_last_key;
  logic [7:0]    r_lfsr;
  logic [7:0]    r_timer;
  logic [TW-1:0] r_tick;
  logic          r_irq;

  logic          w_sel_timer;
  logic          w_sel_status;
  logic          w_sel_random;
  logic          w_sel_key;
  logic          w_rd;
  logic          w_wr;
  logic          w_push;
  logic          w_rep_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_ovf_clr;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic          w_fifo_full_unused;
  logic          w_empty;
  logic          w_overflow;
  logic          w_tick_wrap;
  logic          w_timer_zero;
  logic [7:0]    w_status;
  logic [7:0]    w_rdata;

  assign w_sel_timer  = (cpu_address == ADDR_W'(IO_TIMER));
  assign w_sel_status = (cpu_address == ADDR_W'(IO_STATUS));
  assign w_sel_random = (cpu_address == ADDR_W'(IO_RANDOM));
  assign w_sel_key    = (cpu_address == ADDR_W'(IO_KEY));

  assign w_rd      = cpu_en & ~cpu_read_write;
  assign w_wr      = cpu_en &  cpu_read_write;
  assign w_pop     = w_rd & w_sel_key & ~w_empty;
  assign w_flush   = w_wr & w_sel_status;
  assign w_ovf_clr = w_rd & w_sel_status;
  assign w_push    = (key_valid & ~r_key_prev) | w_rep_push;

`ifdef KEY_AUTOREPEAT_EN
  logic [5:0] r_rep_cnt;

  // First repeat on the 32nd strobe of a hold, then every 8th (24..31 loop).
  assign w_rep_push = key_valid & cpu_en & (r_rep_cnt == 6'd31);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rep_cnt <= '0;
    end else if (!key_valid) begin
      r_rep_cnt <= '0;
    end else if (cpu_en) begin
      r_rep_cnt <= (r_rep_cnt == 6'd31) ? 6'd24 : r_rep_cnt + 6'd1;
    end
  end
`else
  assign w_rep_push = 1'b0;
`endif

  key_fifo #(
    .DEPTH (KEY_DEPTH),
    .DW    (8)
  ) u_key_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_data     (key_code),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .i_ovf_clr  (w_ovf_clr),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_full     (w_fifo_full_unused),
    .o_empty    (w_empty),
    .o_overflow (w_overflow)
  );

  assign w_tick_wrap  = (r_tick == TW'(TICK_DIV - 1));
  assign w_timer_zero = (r_timer == 8'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_prev <= 1'b0;
      r_last_key <= 8'h00;
      r_lfsr     <= RAND_SEED;
      r_timer    <= 8'd0;
      r_tick     <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_key_prev <= key_valid;
      r_irq      <= (w_count != '0);
      if (w_pop) begin
        r_last_key <= w_head;
      end
      if (cpu_en) begin
        r_lfsr <= lfsr_next(r_lfsr);
      end
      if (w_wr && w_sel_timer) begin
        r_timer <= cpu_data_write;
        r_tick  <= '0;
      end else begin
        r_tick <= w_tick_wrap ? '0 : r_tick + TW'(1);
        if (w_tick_wrap && !w_timer_zero) begin
          r_timer <= r_timer - 8'd1;
        end
      end
    end
  end

  always_comb begin
    w_status           = {2'b00, 6'(w_count)};
    w_status[ST_OVF]   = w_overflow;
    w_status[ST_TZERO] = w_timer_zero;
  end

  always_comb begin
    w_rdata = mem_data;
    if (w_sel_timer) begin
      w_rdata = r_timer;
    end else if (w_sel_status) begin
      w_rdata = w_status;
    end else if (w_sel_random) begin
      w_rdata = r_lfsr;
    end else if (w_sel_key) begin
      w_rdata = w_empty ? r_last_key : w_head;
    end
  end

  assign cpu_data_read = w_rdata;
  assign key_irq       = r_irq;

endmodule
`default_nettype wire
